// File: rtl/demo_song_player.sv
// demo_song_player: walks a note ROM and drives PS/2 make/break codes into the tone generator. rev 1.0
// Optional build macro DEMO_SONG_LOOP_EN: replay the note list continuously until stop or reset.
`default_nettype none

module demo_song_player #(
  parameter int STEPS = 58,
  parameter int UNIT  = 16,
  parameter int REL   = 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  output logic [$clog2(STEPS)-1:0] note_addr_o,
  input  logic [7:0]               note_data_i,
  output logic [7:0]               key_code_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int AW = $clog2(STEPS);
  localparam int CW = $clog2(16*UNIT);
  localparam int TW = CW + 1;
  localparam logic [7:0]    KEY_REL   = 8'hF0;
  localparam logic [AW-1:0] LAST_STEP = AW'(STEPS-1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] step_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    pitch_q;
  logic [4:0]    units_q;
  logic [7:0]    key_q;
  logic          busy_q;
  logic          done_q;

  logic [7:0]    pitch_dec;
  logic [4:0]    units_dec;
  logic [TW-1:0] total;
  logic [TW-1:0] cnt_d;

  always_comb begin
    pitch_dec = KEY_REL;
    case (note_data_i[3:0])
      4'd1:    pitch_dec = 8'h2B;
      4'd2:    pitch_dec = 8'h34;
      4'd3:    pitch_dec = 8'h33;
      4'd4:    pitch_dec = 8'h3B;
      4'd5:    pitch_dec = 8'h42;
      4'd6:    pitch_dec = 8'h4B;
      4'd7:    pitch_dec = 8'h4C;
      4'd10:   pitch_dec = 8'h52;
      default: pitch_dec = KEY_REL;
    endcase
  end

  // A zero unit count marks end of song.
  always_comb begin
    units_dec = 5'd0;
    case (note_data_i[7:4])
      4'hF:    units_dec = 5'd1;
      4'h8:    units_dec = 5'd2;
      4'h9:    units_dec = 5'd3;
      4'h1:    units_dec = 5'd4;
      4'h3:    units_dec = 5'd6;
      4'h2:    units_dec = 5'd8;
      4'h4:    units_dec = 5'd16;
      default: units_dec = 5'd0;
    endcase
  end

  assign total = TW'(units_q) * TW'(UNIT);
  assign cnt_d = TW'(cnt_q) + TW'(1);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      pitch_q <= KEY_REL;
      units_q <= '0;
      key_q   <= KEY_REL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state_q <= IDLE;
        step_q  <= '0;
        cnt_q   <= '0;
        key_q   <= KEY_REL;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            key_q  <= KEY_REL;
            step_q <= '0;
            if (start_i) begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
            end
          end
          FETCH: state_q <= LOAD;
          LOAD: begin
            pitch_q <= pitch_dec;
            units_q <= units_dec;
            cnt_q   <= '0;
            if (units_dec == 5'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= PLAY;
              key_q   <= pitch_dec;
            end
          end
          PLAY: begin
            if (!pause_i) begin
              // Key code is registered, so it is computed for the count being entered.
              if (cnt_d == total) begin
                key_q <= KEY_REL;
                cnt_q <= '0;
                if (step_q == LAST_STEP) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  step_q  <= step_q + AW'(1);
                  state_q <= FETCH;
                end
              end else begin
                cnt_q <= cnt_d[CW-1:0];
                key_q <= (cnt_d < total - TW'(REL)) ? pitch_q : KEY_REL;
              end
            end
          end
          DONE: begin
            step_q <= '0;
            key_q  <= KEY_REL;
`ifdef DEMO_SONG_LOOP_EN
            state_q <= FETCH;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign note_addr_o = step_q;
  assign key_code_o  = key_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_demo_song_player.sv
// Directed self-checking bench for demo_song_player with a registered ROM model.
`timescale 1ns/1ps
`default_nettype none

module tb_demo_song_player;
  localparam int STEPS = 58;
  localparam int UNIT  = 16;
  localparam int REL   = 1;
`ifdef DEMO_SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] note_addr;
  logic [7:0] note_data = 8'h00;
  logic [7:0] key_code;
  logic       busy;
  logic       done;
  logic [7:0] rom [0:63];
  int         n_cmp = 0;
  int         n_fail = 0;

  demo_song_player #(.STEPS(STEPS), .UNIT(UNIT), .REL(REL)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .stop_i      (stop),
    .pause_i     (pause),
    .note_addr_o (note_addr),
    .note_data_i (note_data),
    .key_code_o  (key_code),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) note_data <= rom[note_addr];

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
  endtask

  task automatic load_song();
    clear_rom();
    rom[0] = 8'h1A;
    rom[1] = 8'h97;
    rom[2] = 8'h1F;
    rom[3] = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_rom();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (key_code !== 8'hF0) begin n_fail++; $display("FAIL reset_key got %h exp f0", key_code); end
    n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", note_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_song();
    logic [7:0] exp_key;
    load_song();
    pulse_start();
    for (int c = 1; c <= 185; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp_key = (c >= 3 && c <= 65) ? 8'h52 : (c >= 69 && c <= 115) ? 8'h4C : 8'hF0;
      n_cmp++; if (key_code !== exp_key) begin n_fail++; $display("FAIL song_key c=%0d got %h exp %h", c, key_code, exp_key); end
      n_cmp++; if (done !== (c == 185)) begin n_fail++; $display("FAIL song_done c=%0d got %b exp %b", c, done, (c == 185)); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL song_busy c=%0d got %b exp 1", c, busy); end
      if (c <= 184) begin
        n_cmp++;
        if (note_addr !== ((c <= 66) ? 6'd0 : (c <= 116) ? 6'd1 : (c <= 182) ? 6'd2 : 6'd3)) begin
          n_fail++; $display("FAIL song_addr c=%0d got %0d", c, note_addr);
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (busy !== LOOP) begin n_fail++; $display("FAIL song_busy_end got %b exp %b", busy, LOOP); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL song_done_end got %b exp 0", done); end
    n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL song_addr_end got %0d exp 0", note_addr); end
    go_idle();
  endtask

  task automatic test_rest();
    clear_rom();
    rom[0] = 8'h2F;
    pulse_start();
    for (int c = 1; c <= 133; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (key_code !== 8'hF0) begin n_fail++; $display("FAIL rest_key c=%0d got %h exp f0", c, key_code); end
      n_cmp++; if (done !== (c == 133)) begin n_fail++; $display("FAIL rest_done c=%0d got %b exp %b", c, done, (c == 133)); end
      if (c == 130) begin
        n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL rest_addr0 got %0d exp 0", note_addr); end
      end
      if (c == 131) begin
        n_cmp++; if (note_addr !== 6'd1) begin n_fail++; $display("FAIL rest_addr1 got %0d exp 1", note_addr); end
      end
    end
    @(negedge clk);
    n_cmp++; if (busy !== LOOP) begin n_fail++; $display("FAIL rest_busy_end got %b exp %b", busy, LOOP); end
    go_idle();
  endtask

  task automatic test_pause();
    logic [7:0] exp_key;
    clear_rom();
    rom[0] = 8'h11;
    pulse_start();
    for (int c = 1; c <= 89; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp_key = (c >= 3 && c <= 85) ? 8'h2B : 8'hF0;
      n_cmp++; if (key_code !== exp_key) begin n_fail++; $display("FAIL pause_key c=%0d got %h exp %h", c, key_code, exp_key); end
      n_cmp++; if (done !== (c == 89)) begin n_fail++; $display("FAIL pause_done c=%0d got %b exp %b", c, done, (c == 89)); end
      if (c == 10) pause = 1'b1;
      if (c == 30) pause = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (busy !== LOOP) begin n_fail++; $display("FAIL pause_busy_end got %b exp %b", busy, LOOP); end
    go_idle();
  endtask

  task automatic test_stop();
    load_song();
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_busy c=%0d got %b exp 0", c, busy); end
      n_cmp++; if (key_code !== 8'hF0) begin n_fail++; $display("FAIL stop_idle_key c=%0d got %h exp f0", c, key_code); end
    end
    pulse_start();
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++; if (key_code !== 8'h4C) begin n_fail++; $display("FAIL stop_pre_key got %h exp 4c", key_code); end
    n_cmp++; if (note_addr !== 6'd1) begin n_fail++; $display("FAIL stop_pre_addr got %0d exp 1", note_addr); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b exp 0", busy); end
    n_cmp++; if (key_code !== 8'hF0) begin n_fail++; $display("FAIL stop_key got %h exp f0", key_code); end
    n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL stop_addr got %0d exp 0", note_addr); end
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_quiet c=%0d got done=%b busy=%b exp 0 0", c, done, busy); end
    end
  endtask

  task automatic test_async_reset();
    load_song();
    pulse_start();
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (key_code !== 8'hF0) begin n_fail++; $display("FAIL areset_key got %h exp f0", key_code); end
    n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL areset_addr got %0d exp 0", note_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b exp 0", done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL areset_idle c=%0d got busy=%b done=%b exp 0 0", c, busy, done); end
    end
  endtask

  task automatic test_full_steps();
    logic [7:0] exp_key;
    int         o;
    clear_rom();
    for (int i = 0; i < STEPS; i++) rom[i] = 8'hF1;
    pulse_start();
    for (int c = 1; c <= 1044; c++) begin
      @(negedge clk);
      start = 1'b0;
      o = (c - 1) % 18;
      exp_key = (o >= 2 && o <= 16) ? 8'h2B : 8'hF0;
      n_cmp++; if (key_code !== exp_key) begin n_fail++; $display("FAIL full_key c=%0d got %h exp %h", c, key_code, exp_key); end
      n_cmp++; if (note_addr !== 6'((c - 1) / 18)) begin n_fail++; $display("FAIL full_addr c=%0d got %0d exp %0d", c, note_addr, (c - 1) / 18); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_early c=%0d got %b exp 0", c, done); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b exp 1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_done got %b exp 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== LOOP) begin n_fail++; $display("FAIL full_busy_after got %b exp %b", busy, LOOP); end
    n_cmp++; if (note_addr !== 6'd0) begin n_fail++; $display("FAIL full_addr_after got %0d exp 0", note_addr); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_after got %b exp 0", done); end
    repeat (2) @(negedge clk);
    n_cmp++; if (key_code !== (LOOP ? 8'h2B : 8'hF0)) begin n_fail++; $display("FAIL full_wrap_key got %h exp %h", key_code, (LOOP ? 8'h2B : 8'hF0)); end
    go_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_song();
    test_rest();
    test_pause();
    test_stop();
    test_async_reset();
    test_full_steps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
